// File: rtl/branch_chkpt_ctrl.sv
// Branch checkpoint controller: 4 checkpoint slots with age matrix, allocation,
// resolve/free, and mispredict recovery sequencing (IDLE -> RECOVER -> FLUSH -> IDLE).
// Optional build macro CHKPT_SAME_CYCLE_FREE_EN: a slot freed by a correct resolve
// may be re-granted in the same cycle. Default build only grants slots invalid at cycle start.
module branch_chkpt_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       alloc_req,
  input  logic [4:0] alloc_rob_tag,
  output logic       alloc_grant,
  output logic [1:0] alloc_id,
  output logic       full,
  input  logic       resolve_valid,
  input  logic [4:0] resolve_tag,
  input  logic       resolve_mispredict,
  output logic       recover_valid,
  output logic [1:0] recover_id,
  output logic [3:0] squash_mask,
  input  logic       flush_done,
  output logic       stall,
  output logic [2:0] occupancy
);

  typedef enum logic [1:0] {IDLE, RECOVER, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [3:0] valid_q, valid_d;
  logic [4:0] tag_q [4];
  logic [4:0] tag_d [4];
  logic [3:0] younger_q [4];   // younger_q[i][j]: slot i allocated after slot j
  logic [3:0] younger_d [4];
  logic [1:0] rec_id_q, rec_id_d;
  logic [3:0] rec_mask_q, rec_mask_d;

  logic       hit;
  logic [1:0] hit_id;
  logic [3:0] free_oh;
  logic       mis_hit;
  logic [3:0] mis_mask;
  logic [3:0] avail;
  logic [1:0] gnt_id;
  logic       gnt;
  logic [3:0] clr;

  // Resolve tag lookup (tags of live slots are unique; lowest index wins anyway)
  always_comb begin
    hit    = 1'b0;
    hit_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (resolve_valid && valid_q[i] && (tag_q[i] == resolve_tag)) begin
        hit    = 1'b1;
        hit_id = 2'(i);
      end
    end
  end

  // Free/squash/grant decode: mispredict only acts in IDLE and blocks allocation
  always_comb begin
    free_oh  = (hit && !resolve_mispredict) ? (4'b0001 << hit_id) : 4'b0000;
    mis_hit  = hit && resolve_mispredict && (state_q == IDLE);
    mis_mask = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      mis_mask[j] = (2'(j) == hit_id) || (valid_q[j] && younger_q[j][hit_id]);
    end
`ifdef CHKPT_SAME_CYCLE_FREE_EN
    avail = ~valid_q | free_oh;
`else
    avail = ~valid_q;
`endif
    gnt_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (avail[i]) gnt_id = 2'(i);
    end
    gnt = alloc_req && !reset && (state_q == IDLE) && !mis_hit && (|avail);
  end

  // Next-state: slot table, age matrix and recovery FSM
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    younger_d  = younger_q;
    rec_id_d   = rec_id_q;
    rec_mask_d = rec_mask_q;
    clr        = free_oh | ((state_q == RECOVER) ? rec_mask_q : 4'b0000);

    for (int i = 0; i < 4; i++) begin
      if (clr[i]) begin
        valid_d[i]   = 1'b0;
        younger_d[i] = 4'b0000;
        for (int j = 0; j < 4; j++) younger_d[j][i] = 1'b0;
      end
    end

    // New slot is younger than every slot still live after this cycle's frees
    if (gnt) begin
      younger_d[gnt_id] = valid_d;
      for (int j = 0; j < 4; j++) younger_d[j][gnt_id] = 1'b0;
      valid_d[gnt_id] = 1'b1;
      tag_d[gnt_id]   = alloc_rob_tag;
    end

    case (state_q)
      IDLE: begin
        if (mis_hit) begin
          state_d    = RECOVER;
          rec_id_d   = hit_id;
          rec_mask_d = mis_mask;
        end
      end
      RECOVER: state_d = FLUSH;
      FLUSH:   if (flush_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 4'b0000;
      rec_id_q   <= 2'd0;
      rec_mask_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]     <= 5'd0;
        younger_q[i] <= 4'b0000;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rec_id_q   <= rec_id_d;
      rec_mask_q <= rec_mask_d;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]     <= tag_d[i];
        younger_q[i] <= younger_d[i];
      end
    end
  end

  // Outputs: recovery command only visible during RECOVER
  always_comb begin
    alloc_grant   = gnt;
    alloc_id      = gnt ? gnt_id : 2'd0;
    full          = &valid_q;
    recover_valid = (state_q == RECOVER);
    recover_id    = recover_valid ? rec_id_q : 2'd0;
    squash_mask   = recover_valid ? rec_mask_q : 4'b0000;
    stall         = (state_q != IDLE) || full;
    occupancy     = {2'b00, valid_q[0]} + {2'b00, valid_q[1]}
                  + {2'b00, valid_q[2]} + {2'b00, valid_q[3]};
  end

endmodule

// File: tb/tb_branch_chkpt_ctrl.sv
// Self-checking bench for branch_chkpt_ctrl: grants and recovery commands are
// checked through scoreboard queues; state outputs are checked directly.
module tb_branch_chkpt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [4:0] alloc_rob_tag;
  logic       alloc_grant;
  logic [1:0] alloc_id;
  logic       full;
  logic       resolve_valid;
  logic [4:0] resolve_tag;
  logic       resolve_mispredict;
  logic       recover_valid;
  logic [1:0] recover_id;
  logic [3:0] squash_mask;
  logic       flush_done;
  logic       stall;
  logic [2:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;
  int         exp_gnt_q[$];
  logic [5:0] exp_rec_q[$];   // {recover_id, squash_mask}

  always #5 clk = ~clk;

  branch_chkpt_ctrl dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_rob_tag(alloc_rob_tag),
    .alloc_grant(alloc_grant), .alloc_id(alloc_id), .full(full),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .recover_valid(recover_valid), .recover_id(recover_id), .squash_mask(squash_mask),
    .flush_done(flush_done), .stall(stall), .occupancy(occupancy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_req          = 1'b0;
    alloc_rob_tag      = 5'd0;
    resolve_valid      = 1'b0;
    resolve_tag        = 5'd0;
    resolve_mispredict = 1'b0;
    flush_done         = 1'b0;
  endtask

  // Sample mid-cycle; pop scoreboards when the DUT produces a grant or recovery
  task automatic sample();
    @(negedge clk);
    if (alloc_grant) begin
      if (exp_gnt_q.size() == 0) check_eq("grant_unexpected", alloc_grant, 0);
      else check_eq("alloc_id", alloc_id, exp_gnt_q.pop_front());
    end
    if (recover_valid) begin
      if (exp_rec_q.size() == 0) check_eq("recover_unexpected", recover_valid, 0);
      else check_eq("recover_id_mask", {recover_id, squash_mask}, exp_rec_q.pop_front());
    end
  endtask

  task automatic adv();
    if (exp_gnt_q.size() != 0) begin
      check_eq("grant_missing", exp_gnt_q.size(), 0);
      exp_gnt_q.delete();
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_alloc(input logic [4:0] t, input int exp_id);
    alloc_req     = 1'b1;
    alloc_rob_tag = t;
    if (exp_id >= 0) exp_gnt_q.push_back(exp_id);
    sample();
    check_eq("grant_flag", alloc_grant, (exp_id >= 0) ? 1 : 0);
    adv();
  endtask

  task automatic check_reset_outs(input string pfx);
    check_eq({pfx, "_grant"}, alloc_grant, 0);
    check_eq({pfx, "_id"}, alloc_id, 0);
    check_eq({pfx, "_full"}, full, 0);
    check_eq({pfx, "_rvalid"}, recover_valid, 0);
    check_eq({pfx, "_rid"}, recover_id, 0);
    check_eq({pfx, "_mask"}, squash_mask, 0);
    check_eq({pfx, "_stall"}, stall, 0);
    check_eq({pfx, "_occ"}, occupancy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state, with alloc_req high while reset is held
    reset = 1'b1;
    idle_inputs();
    alloc_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    check_reset_outs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();

    // Four allocations fill slots 0..3, fifth gets nothing
    do_alloc(5'd3, 0);
    do_alloc(5'd7, 1);
    do_alloc(5'd9, 2);
    do_alloc(5'd12, 3);
    alloc_req = 1'b1; alloc_rob_tag = 5'd15;
    sample();
    check_eq("full4", full, 1);
    check_eq("occ4", occupancy, 4);
    check_eq("stall_full", stall, 1);
    check_eq("no_grant_full", alloc_grant, 0);
    adv();

    // Correct resolve of tag 7 frees slot 1, which is re-granted
    resolve_valid = 1'b1; resolve_tag = 5'd7;
    sample();
    adv();
    sample();
    check_eq("occ_after_free", occupancy, 3);
    check_eq("full_after_free", full, 0);
    check_eq("stall_after_free", stall, 0);
    adv();
    do_alloc(5'd20, 1);    // age order now 0,2,3,1

    // Same-cycle free of tag 3 with an alloc while full
    resolve_valid = 1'b1; resolve_tag = 5'd3;
`ifdef CHKPT_SAME_CYCLE_FREE_EN
    do_alloc(5'd5, 0);
`else
    do_alloc(5'd5, -1);
    sample();
    check_eq("occ_free3", occupancy, 3);
    adv();
    do_alloc(5'd5, 0);
`endif
    sample();
    check_eq("occ_refill", occupancy, 4);
    adv();                 // age order now 2,3,1,0

    // Mispredict of tag 12 (slot 3) squashes it and the younger slots 1 and 0
    resolve_valid = 1'b1; resolve_tag = 5'd12; resolve_mispredict = 1'b1;
    alloc_req = 1'b1; alloc_rob_tag = 5'd6;
    exp_rec_q.push_back({2'd3, 4'b1011});
    sample();
    check_eq("mis_prio_grant", alloc_grant, 0);
    adv();
    sample();
    check_eq("rec_valid_a", recover_valid, 1);
    check_eq("rec_stall_a", stall, 1);
    adv();
    flush_done = 1'b1;
    sample();
    check_eq("occ_after_sq_a", occupancy, 1);
    check_eq("flush_stall_a", stall, 1);
    adv();
    sample();
    check_eq("idle_stall_a", stall, 0);
    adv();

    // Ordered allocation, mispredict tag 7 squashes slots 1..3
    do_reset();
    do_alloc(5'd3, 0);
    do_alloc(5'd7, 1);
    do_alloc(5'd9, 2);
    do_alloc(5'd12, 3);
    resolve_valid = 1'b1; resolve_tag = 5'd7; resolve_mispredict = 1'b1;
    alloc_req = 1'b1;
    exp_rec_q.push_back({2'd1, 4'b1110});
    sample();
    check_eq("mis_prio_grant_b", alloc_grant, 0);
    adv();
    alloc_req = 1'b1;
    sample();
    check_eq("rec_valid_b", recover_valid, 1);
    check_eq("rec_grant_b", alloc_grant, 0);
    adv();
    sample();
    check_eq("rec_one_cycle", recover_valid, 0);
    check_eq("occ_after_sq_b", occupancy, 1);
    adv();

    // Hold flush_done low: stay stalled, no grants; a late mispredict is ignored
    for (int k = 0; k < 5; k++) begin
      alloc_req = 1'b1; alloc_rob_tag = 5'd4;
      if (k == 2) begin
        resolve_valid = 1'b1; resolve_tag = 5'd3; resolve_mispredict = 1'b1;
      end
      sample();
      check_eq("flush_stall", stall, 1);
      check_eq("flush_grant", alloc_grant, 0);
      check_eq("flush_rvalid", recover_valid, 0);
      adv();
    end
    flush_done = 1'b1;
    sample();
    check_eq("flush_done_stall", stall, 1);
    adv();
    sample();
    check_eq("back_idle_stall", stall, 0);
    check_eq("ignored_mis_occ", occupancy, 1);
    adv();
    do_alloc(5'd4, 1);

    // Non-matching resolve changes nothing
    resolve_valid = 1'b1; resolve_tag = 5'd30;
    sample();
    adv();
    sample();
    check_eq("nomatch_occ", occupancy, 2);
    adv();

    // Reset during FLUSH abandons recovery
    resolve_valid = 1'b1; resolve_tag = 5'd4; resolve_mispredict = 1'b1;
    exp_rec_q.push_back({2'd1, 4'b0010});
    sample();
    adv();
    sample();
    check_eq("rec_valid_c", recover_valid, 1);
    adv();
    reset = 1'b1;
    sample();
    check_eq("flush_stall_c", stall, 1);
    adv();
    reset = 1'b0;
    sample();
    check_reset_outs("flushrst");
    adv();
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("post_rst_rvalid", recover_valid, 0);
      adv();
    end

    check_eq("rec_queue_left", exp_rec_q.size(), 0);
    check_eq("gnt_queue_left", exp_gnt_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
